// File: rtl/fpga_memory_if.sv
// CPU BRAM-style bus into the memory hub: one access per cycle, no handshake.
interface fpga_memory_if;
  logic        CPU_EN;
  logic        CPU_WE;
  logic [1:0]  CPU_SEL;
  logic [13:0] CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;

  modport master (output CPU_EN, CPU_WE, CPU_SEL, CPU_ADDR, CPU_DIN, input CPU_DOUT);
  modport slave  (input CPU_EN, CPU_WE, CPU_SEL, CPU_ADDR, CPU_DIN, output CPU_DOUT);
endinterface

// File: rtl/fpga_memory.sv
// Host-to-fabric memory hub: decodes the CPU bus into ctrl regs, phase-correction,
// two-segment modulation and STM tables, and the PWE table, each with a 1-cycle read port.
module fpga_memory #(
  parameter int MOD_AW = 14,
  parameter int STM_AW = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  fpga_memory_if.slave        cpu,
  input  logic [7:0]          CNT_ADDR,
  input  logic                CNT_WE,
  input  logic [15:0]         CNT_DIN,
  output logic [15:0]         CNT_DOUT,
  input  logic [7:0]          PC_IDX,
  output logic [7:0]          PC_DATA,
  input  logic                MOD_SEG,
  input  logic [MOD_AW:0]     MOD_IDX,
  output logic [7:0]          MOD_DATA,
  input  logic                STM_SEG,
  input  logic [STM_AW-1:0]   STM_IDX,
  output logic [63:0]         STM_DATA,
  input  logic [7:0]          PWE_IDX,
  output logic [7:0]          PWE_DATA
);
  localparam int STM_PW = STM_AW + 2 - 14;

  logic [15:0] ctrl_mem [256];
  logic [15:0] pc_mem   [128];
  logic [15:0] pwe_mem  [128];
  logic [15:0] mod_mem  [2][2**MOD_AW];
  logic [63:0] stm_mem  [2][2**STM_AW];

  logic              mod_wr_seg_q, mod_wr_seg_d;
  logic              stm_wr_seg_q, stm_wr_seg_d;
  logic [STM_PW-1:0] stm_wr_page_q, stm_wr_page_d;

  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic [15:0] cnt_dout_q, cnt_dout_d;
  logic [7:0]  pc_data_q, pc_data_d;
  logic [7:0]  mod_data_q, mod_data_d;
  logic [63:0] stm_data_q, stm_data_d;
  logic [7:0]  pwe_data_q, pwe_data_d;

  logic wr, rd, ctrl_hit, pc_hit;
  logic ctrl_wr, pc_wr, mod_wr, pwe_wr, stm_wr, cnt_wr;
  logic [STM_AW+1:0] stm_flat;
  logic [15:0] pc_word, mod_word, pwe_word;

  // Writes are gated by RST_N so a write overlapping reset is dropped whole.
  always_comb begin
    wr       = cpu.CPU_EN & cpu.CPU_WE & RST_N;
    rd       = cpu.CPU_EN & ~cpu.CPU_WE;
    ctrl_hit = (cpu.CPU_SEL == 2'd0) && (cpu.CPU_ADDR[13:8] == 6'd0);
    pc_hit   = (cpu.CPU_SEL == 2'd0) && (cpu.CPU_ADDR[13:8] == 6'd1);
    ctrl_wr  = wr & ctrl_hit;
    pc_wr    = wr & pc_hit;
    mod_wr   = wr & (cpu.CPU_SEL == 2'd1);
    pwe_wr   = wr & (cpu.CPU_SEL == 2'd2);
    stm_wr   = wr & (cpu.CPU_SEL == 2'd3);
    cnt_wr   = CNT_WE & RST_N & ~(ctrl_wr && (CNT_ADDR == cpu.CPU_ADDR[7:0]));
    stm_flat = {stm_wr_page_q, cpu.CPU_ADDR};
  end

  always_comb begin
    mod_wr_seg_d  = mod_wr_seg_q;
    stm_wr_seg_d  = stm_wr_seg_q;
    stm_wr_page_d = stm_wr_page_q;
    if (ctrl_wr) begin
      case (cpu.CPU_ADDR[7:0])
        8'h06:   mod_wr_seg_d  = cpu.CPU_DIN[0];
        8'h07:   stm_wr_seg_d  = cpu.CPU_DIN[0];
        8'h08:   stm_wr_page_d = cpu.CPU_DIN[STM_PW-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (cnt_wr)  ctrl_mem[CNT_ADDR] <= CNT_DIN;
    if (ctrl_wr) ctrl_mem[cpu.CPU_ADDR[7:0]] <= cpu.CPU_DIN;
  end

  always_ff @(posedge CLK) begin
    if (pc_wr)  pc_mem[cpu.CPU_ADDR[6:0]]  <= cpu.CPU_DIN;
    if (pwe_wr) pwe_mem[cpu.CPU_ADDR[6:0]] <= cpu.CPU_DIN;
  end

  always_ff @(posedge CLK) begin
    if (mod_wr) mod_mem[mod_wr_seg_q][cpu.CPU_ADDR[MOD_AW-1:0]] <= cpu.CPU_DIN;
  end

  always_ff @(posedge CLK) begin
    if (stm_wr)
      stm_mem[stm_wr_seg_q][stm_flat[STM_AW+1:2]][{stm_flat[1:0], 4'b0000} +: 16] <= cpu.CPU_DIN;
  end

  // Reads sample the arrays before this cycle's writes land, giving read-first behaviour.
  always_comb begin
    cpu_dout_d = cpu_dout_q;
    if (rd) begin
      if (ctrl_hit)    cpu_dout_d = ctrl_mem[cpu.CPU_ADDR[7:0]];
      else if (pc_hit) cpu_dout_d = pc_mem[cpu.CPU_ADDR[6:0]];
      else             cpu_dout_d = '0;
    end
    cnt_dout_d = ctrl_mem[CNT_ADDR];
    pc_word    = pc_mem[PC_IDX[7:1]];
    pc_data_d  = PC_IDX[0] ? pc_word[15:8] : pc_word[7:0];
    mod_word   = mod_mem[MOD_SEG][MOD_IDX[MOD_AW:1]];
    mod_data_d = MOD_IDX[0] ? mod_word[15:8] : mod_word[7:0];
    pwe_word   = pwe_mem[PWE_IDX[7:1]];
    pwe_data_d = PWE_IDX[0] ? pwe_word[15:8] : pwe_word[7:0];
    stm_data_d = stm_mem[STM_SEG][STM_IDX];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mod_wr_seg_q  <= 1'b0;
      stm_wr_seg_q  <= 1'b0;
      stm_wr_page_q <= '0;
      cpu_dout_q    <= '0;
      cnt_dout_q    <= '0;
      pc_data_q     <= '0;
      mod_data_q    <= '0;
      stm_data_q    <= '0;
      pwe_data_q    <= '0;
    end else begin
      mod_wr_seg_q  <= mod_wr_seg_d;
      stm_wr_seg_q  <= stm_wr_seg_d;
      stm_wr_page_q <= stm_wr_page_d;
      cpu_dout_q    <= cpu_dout_d;
      cnt_dout_q    <= cnt_dout_d;
      pc_data_q     <= pc_data_d;
      mod_data_q    <= mod_data_d;
      stm_data_q    <= stm_data_d;
      pwe_data_q    <= pwe_data_d;
    end
  end

  assign cpu.CPU_DOUT = cpu_dout_q;
  assign CNT_DOUT     = cnt_dout_q;
  assign PC_DATA      = pc_data_q;
  assign MOD_DATA     = mod_data_q;
  assign STM_DATA     = stm_data_q;
  assign PWE_DATA     = pwe_data_q;
endmodule

// File: tb/tb_fpga_memory.sv
// Directed bench for fpga_memory: expectations queued at drive time, compared one cycle later.
module tb_fpga_memory;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  CNT_ADDR;
  logic        CNT_WE;
  logic [15:0] CNT_DIN;
  logic [15:0] CNT_DOUT;
  logic [7:0]  PC_IDX;
  logic [7:0]  PC_DATA;
  logic        MOD_SEG;
  logic [14:0] MOD_IDX;
  logic [7:0]  MOD_DATA;
  logic        STM_SEG;
  logic [15:0] STM_IDX;
  logic [63:0] STM_DATA;
  logic [7:0]  PWE_IDX;
  logic [7:0]  PWE_DATA;

  fpga_memory_if cpu_bus ();

  fpga_memory #(.MOD_AW(14), .STM_AW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .cpu(cpu_bus),
    .CNT_ADDR(CNT_ADDR), .CNT_WE(CNT_WE), .CNT_DIN(CNT_DIN), .CNT_DOUT(CNT_DOUT),
    .PC_IDX(PC_IDX), .PC_DATA(PC_DATA),
    .MOD_SEG(MOD_SEG), .MOD_IDX(MOD_IDX), .MOD_DATA(MOD_DATA),
    .STM_SEG(STM_SEG), .STM_IDX(STM_IDX), .STM_DATA(STM_DATA),
    .PWE_IDX(PWE_IDX), .PWE_DATA(PWE_DATA)
  );

  always #5 CLK = ~CLK;

  localparam int P_CPU = 0, P_CNT = 1, P_PC = 2, P_MOD = 3, P_STM = 4, P_PWE = 5;

  typedef struct {
    string       tag;
    int          port;
    logic [63:0] exp;
    logic [63:0] mask;
  } sb_t;

  sb_t         sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_stm [2][16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [63:0] exp,
                      input logic [63:0] mask = '1);
    sb_t e;
    e.tag = tag; e.port = port; e.exp = exp; e.mask = mask;
    sbq.push_back(e);
  endtask

  function automatic logic [63:0] observe(input int port);
    case (port)
      P_CPU:   return {48'd0, cpu_bus.CPU_DOUT};
      P_CNT:   return {48'd0, CNT_DOUT};
      P_PC:    return {56'd0, PC_DATA};
      P_MOD:   return {56'd0, MOD_DATA};
      P_STM:   return STM_DATA;
      default: return {56'd0, PWE_DATA};
    endcase
  endfunction

  // Compare everything queued last cycle, then release the bus for the caller to drive.
  task automatic tick();
    sb_t e;
    @(negedge CLK);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.port) & e.mask, e.exp & e.mask);
    end
    cpu_bus.CPU_EN = 1'b0;
    cpu_bus.CPU_WE = 1'b0;
    CNT_WE = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] sel, input logic [13:0] addr, input logic [15:0] data);
    tick();
    cpu_bus.CPU_EN = 1'b1; cpu_bus.CPU_WE = 1'b1;
    cpu_bus.CPU_SEL = sel; cpu_bus.CPU_ADDR = addr; cpu_bus.CPU_DIN = data;
  endtask

  task automatic cpu_rd(input string tag, input logic [1:0] sel, input logic [13:0] addr,
                        input logic [15:0] exp);
    tick();
    cpu_bus.CPU_EN = 1'b1; cpu_bus.CPU_WE = 1'b0;
    cpu_bus.CPU_SEL = sel; cpu_bus.CPU_ADDR = addr;
    push(tag, P_CPU, {48'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu"}, {48'd0, cpu_bus.CPU_DOUT}, '0);
    check({tag, "_cnt"}, {48'd0, CNT_DOUT}, '0);
    check({tag, "_pc"},  {56'd0, PC_DATA}, '0);
    check({tag, "_mod"}, {56'd0, MOD_DATA}, '0);
    check({tag, "_stm"}, STM_DATA, '0);
    check({tag, "_pwe"}, {56'd0, PWE_DATA}, '0);
  endtask

  initial begin
    logic [15:0] w;
    RST_N = 1'b0;
    cpu_bus.CPU_EN = 1'b0; cpu_bus.CPU_WE = 1'b0; cpu_bus.CPU_SEL = '0;
    cpu_bus.CPU_ADDR = '0; cpu_bus.CPU_DIN = '0;
    CNT_ADDR = '0; CNT_WE = 1'b0; CNT_DIN = '0;
    PC_IDX = '0; MOD_SEG = 1'b0; MOD_IDX = '0; STM_SEG = 1'b0; STM_IDX = '0; PWE_IDX = '0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // STM: 16 entries x 4 lanes into each segment, then read back
    for (int s = 0; s < 2; s++) begin
      cpu_wr(2'd0, 14'h0007, 16'(s));
      for (int e = 0; e < 16; e++) begin
        for (int l = 0; l < 4; l++) begin
          w = 16'(16'h1000 * (s + 1) + 16'h0100 * l + e);
          exp_stm[s][e][l*16 +: 16] = w;
          cpu_wr(2'd3, 14'(e * 4 + l), w);
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      for (int e = 0; e < 16; e++) begin
        tick();
        STM_SEG = 1'(s); STM_IDX = 16'(e);
        push($sformatf("stm_s%0d_e%0d", s, e), P_STM, exp_stm[s][e]);
      end
    end

    // STM page 1 -> entry 4096 of segment 1
    cpu_wr(2'd0, 14'h0008, 16'h0001);
    cpu_wr(2'd3, 14'h0000, 16'hBEEF);
    tick(); STM_SEG = 1'b1; STM_IDX = 16'd4096;
    push("stm_page_lane0", P_STM, 64'h0000_0000_0000_BEEF, 64'h0000_0000_0000_FFFF);
    tick(); STM_IDX = 16'd0;
    push("stm_page_idx0", P_STM, exp_stm[1][0]);
    cpu_wr(2'd0, 14'h0008, 16'h0000);

    // Modulation segments
    cpu_wr(2'd1, 14'd3, 16'h5566);
    cpu_wr(2'd0, 14'h0006, 16'h0001);
    cpu_wr(2'd1, 14'd3, 16'h12AB);
    tick(); MOD_SEG = 1'b1; MOD_IDX = 15'd6; push("mod_s1_i6", P_MOD, 64'hAB);
    tick(); MOD_IDX = 15'd7; push("mod_s1_i7", P_MOD, 64'h12);
    tick(); MOD_SEG = 1'b0; MOD_IDX = 15'd6; push("mod_s0_i6", P_MOD, 64'h66);
    tick(); MOD_IDX = 15'd7; push("mod_s0_i7", P_MOD, 64'h55);

    // Control registers and CNT write-back
    cpu_wr(2'd0, 14'h0010, 16'h5A5A);
    tick(); CNT_ADDR = 8'h10; push("cnt_rd_10", P_CNT, 64'h5A5A);
    tick(); CNT_WE = 1'b1; CNT_ADDR = 8'h11; CNT_DIN = 16'h1234;
    cpu_rd("cpu_rd_11", 2'd0, 14'h0011, 16'h1234);
    tick(); push("cpu_dout_hold", P_CPU, 64'h1234);
    cpu_rd("cpu_rd_sel1_zero", 2'd1, 14'h0003, 16'h0000);
    cpu_rd("cpu_rd_unmapped", 2'd0, 14'h0210, 16'h0000);
    cpu_wr(2'd0, 14'h0012, 16'h7777);
    CNT_WE = 1'b1; CNT_ADDR = 8'h12; CNT_DIN = 16'h8888;
    tick(); CNT_ADDR = 8'h12; push("cnt_cpu_wins", P_CNT, 64'h7777);

    // PWE and phase correction, including PWE address wrap
    cpu_wr(2'd2, 14'h0000, 16'h0201);
    cpu_wr(2'd2, 14'h0085, 16'h0403);
    cpu_wr(2'd0, 14'h0100, 16'hCDEF);
    tick(); PWE_IDX = 8'd0; PC_IDX = 8'd1;
    push("pwe_i0", P_PWE, 64'h01); push("pc_i1", P_PC, 64'hCD);
    tick(); PWE_IDX = 8'd1; PC_IDX = 8'd0;
    push("pwe_i1", P_PWE, 64'h02); push("pc_i0", P_PC, 64'hEF);
    tick(); PWE_IDX = 8'd10; push("pwe_wrap_i10", P_PWE, 64'h03);
    tick(); PWE_IDX = 8'd11; push("pwe_wrap_i11", P_PWE, 64'h04);
    cpu_rd("cpu_rd_pc", 2'd0, 14'h0100, 16'hCDEF);

    // Same-cycle STM write and read of entry 5: read-first
    cpu_wr(2'd0, 14'h0007, 16'h0000);
    cpu_wr(2'd3, 14'd21, 16'hAAAA);
    STM_SEG = 1'b0; STM_IDX = 16'd5;
    push("stm_rf_old", P_STM, exp_stm[0][5]);
    exp_stm[0][5][31:16] = 16'hAAAA;
    tick(); push("stm_rf_new", P_STM, exp_stm[0][5]);
    cpu_wr(2'd0, 14'h0020, 16'h1111);
    tick();

    // Reset pulse: outputs clear asynchronously, a write during reset is lost
    #2 RST_N = 1'b0;
    #1 check_all_zero("rst_pulse");
    @(negedge CLK);
    cpu_bus.CPU_EN = 1'b1; cpu_bus.CPU_WE = 1'b1;
    cpu_bus.CPU_SEL = 2'd0; cpu_bus.CPU_ADDR = 14'h0020; cpu_bus.CPU_DIN = 16'hFFFF;
    @(negedge CLK);
    cpu_bus.CPU_EN = 1'b0; cpu_bus.CPU_WE = 1'b0;
    RST_N = 1'b1;
    cpu_rd("cpu_rd_after_rst", 2'd0, 14'h0020, 16'h1111);
    tick(); STM_SEG = 1'b0; STM_IDX = 16'd3;
    push("stm_after_rst", P_STM, exp_stm[0][3]);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
